axis_fifo_s_v1_0_s_axis: RTL and testbench
==========================================

# axis_fifo_s_v1_0_S_AXIS

AXI4-Stream slave that accepts fixed-length frames from an upstream master and writes every accepted beat into a write-side FIFO. It is the receive-side counterpart of the FIFO-fed AXIS master. It admits a new frame only when the FIFO reports room for a whole frame, and checks TLAST against the configured frame length. It also counts completed frames and flags length errors.

## Interface
- C_S_AXIS_TDATA_WIDTH, 32, TDATA width in bits; multiple of 8.
- LENGTH_OF_FRAME, 1024, beats per frame; ≥ 2.
- S_AXIS_ACLK  in  1  single clock; all logic on rising edge.
- S_AXIS_ARESET  in  1  reset, asynchronous, active-high.
- S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  stream payload.
- S_AXIS_TKEEP  in  C_S_AXIS_TDATA_WIDTH/8  byte qualifier; ignored, all bytes written.
- S_AXIS_TLAST  in  1  frame boundary from master.
- S_AXIS_TVALID  in  1  master has a beat.
- S_AXIS_TREADY  out  1  slave accepts a beat this cycle.
- din  out  C_S_AXIS_TDATA_WIDTH  FIFO write data, equals S_AXIS_TDATA.
- wr_en  out  1  FIFO write enable.
- prog_full  in  1  FIFO free space < LENGTH_OF_FRAME.
- full  in  1  FIFO cannot take a write this cycle.
- frame_cnt  out  16  completed frames, wraps at 65535→0.
- err_short  out  1  one-cycle pulse: TLAST arrived before the last beat.
- err_long  out  1  one-cycle pulse: last beat arrived without TLAST.
- busy  out  1  high while in RECV.

## Operation
- States: IDLE → WAIT_SPACE → RECV → WAIT_SPACE … State register and beat counter are cleared by reset.
- IDLE: unconditional move to WAIT_SPACE after one cycle.
- WAIT_SPACE: move to RECV when prog_full = 0; otherwise stay.
- RECV:
  - TREADY = ~full, combinational.
  - beat = TVALID & TREADY.
  - wr_en = beat; din = TDATA. Both combinational, with no data register.
- beat_cnt (width clogb2(LENGTH_OF_FRAME-1)+1) increments on each beat and resets to 0 when a frame ends.
- Frame end is the beat where beat_cnt = LENGTH_OF_FRAME-1, or the beat where TLAST = 1, whichever comes first. On frame end:
  - frame_cnt += 1.
  - beat_cnt ← 0.
  - state ← WAIT_SPACE.
- Length checks at frame end:
  - TLAST = 1 with beat_cnt < LENGTH_OF_FRAME-1: err_short pulses. The short frame is still written and counted.
  - beat_cnt = LENGTH_OF_FRAME-1 with TLAST = 0: err_long pulses. The frame is closed anyway. The next beat starts a new frame at count 0 and is not dropped.
  - TLAST = 1 on beat LENGTH_OF_FRAME-1: normal frame, no error.
- full rising mid-frame: TREADY drops in the same cycle and no write occurs. The frame resumes when full falls, with no beat lost or duplicated.
- prog_full is sampled only in WAIT_SPACE. Its changes during RECV are ignored.
- TVALID while in IDLE or WAIT_SPACE: the beat is held off (TREADY = 0). No write.

## Timing
- Reset values: TREADY 0, wr_en 0, frame_cnt 0, err_short 0, err_long 0, busy 0, state IDLE.
- Reset assertion takes effect immediately, with no clock needed. Assertion mid-frame abandons the partial frame. frame_cnt does not count it, and FIFO contents belong to the FIFO's own reset.
- After reset release with prog_full = 0:
  - edge 1: state is WAIT_SPACE.
  - edge 2: state is RECV; TREADY = 1 from then on.
- Write latency is 0: wr_en and din are asserted in the same cycle as the accepted handshake.
- Frame end accepted in cycle N:
  - cycle N+1: WAIT_SPACE, TREADY = 0. frame_cnt is updated, busy = 0, error pulse visible if any.
  - cycle N+2 at the earliest: RECV again.
  - This gives a minimum one-cycle gap between frames.
- Error pulses are registered and exactly one cycle wide.

## Test plan
- Reset release, prog_full=0, LENGTH_OF_FRAME=8, TVALID held high, TLAST on beat 7 → TREADY high 2 cycles after release; 8 writes with din matching TDATA 0..7; frame_cnt=1; no error pulses; TREADY low for 1 cycle, then high again.
- prog_full=1 at frame boundary for 5 cycles → TREADY stays 0 for those cycles; no wr_en; RECV entered on the edge after prog_full falls.
- full asserted on beat 3 for 4 cycles → TREADY and wr_en low for those 4 cycles; beats 3..7 written after full falls with data in order; 8 writes total.
- TLAST on beat 4 of 8 → err_short pulses 1 cycle after beat 4; frame_cnt +1; next beat counted as beat 0 of a new frame.
- 12 beats with no TLAST → err_long pulse after beat 7; frame_cnt=1 after beat 7; beats 8..11 written as new frame beats 0..3.
- Async reset asserted mid-frame on beat 5 → TREADY, wr_en, frame_cnt and busy go to 0 with no clock edge; after release the next frame counts from beat 0.

Source files
------------

// File: rtl/axis_fifo_s_v1_0_s_axis_if.sv
// AXI4-Stream beat bundle between an upstream master and the FIFO-fed slave.
// TKEEP is carried for completeness; the slave writes every byte regardless.
interface axis_fifo_s_v1_0_s_axis_if #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32
);
  logic [C_S_AXIS_TDATA_WIDTH-1:0]   TDATA;
  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] TKEEP;
  logic                              TLAST;
  logic                              TVALID;
  logic                              TREADY;

  modport master (
    output TDATA,
    output TKEEP,
    output TLAST,
    output TVALID,
    input  TREADY
  );

  modport slave (
    input  TDATA,
    input  TKEEP,
    input  TLAST,
    input  TVALID,
    output TREADY
  );
endinterface

// File: rtl/axis_fifo_s_v1_0_s_axis.sv
// AXI4-Stream slave that writes fixed-length frames into a FIFO, admitting a frame
// only when a whole frame fits, and reporting frame count and TLAST length errors.
module axis_fifo_s_v1_0_s_axis #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int LENGTH_OF_FRAME      = 1024
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESET,
  axis_fifo_s_v1_0_s_axis_if.slave        s_axis,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] din,
  output logic                            wr_en,
  input  logic                            prog_full,
  input  logic                            full,
  output logic [15:0]                     frame_cnt,
  output logic                            err_short,
  output logic                            err_long,
  output logic                            busy
);

  function automatic int unsigned clogb2(input int unsigned depth);
    int unsigned d;
    int unsigned n;
    d = depth;
    n = 0;
    while (d > 0) begin
      n++;
      d = d >> 1;
    end
    return n;
  endfunction

  localparam int unsigned CNT_W = clogb2(LENGTH_OF_FRAME - 1) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LENGTH_OF_FRAME - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    RECV       = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;

  logic tready;
  logic beat;
  logic at_last;
  logic frame_end;

  // Byte qualifiers are deliberately ignored: every beat is written whole.
  logic unused_tkeep;
  assign unused_tkeep = ^s_axis.TKEEP;

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    tready      = 1'b0;
    beat        = 1'b0;
    at_last     = (beat_cnt_q == LAST_BEAT);
    frame_end   = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = WAIT_SPACE;
      end
      WAIT_SPACE: begin
        if (!prog_full) begin
          state_d = RECV;
        end
      end
      RECV: begin
        tready    = ~full;
        beat      = s_axis.TVALID & tready;
        frame_end = beat & (s_axis.TLAST | at_last);
        if (frame_end) begin
          // A missing TLAST still closes the frame at its nominal length, so the
          // next beat opens a fresh frame rather than being dropped.
          state_d     = WAIT_SPACE;
          beat_cnt_d  = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          err_short_d = s_axis.TLAST & ~at_last;
          err_long_d  = ~s_axis.TLAST & at_last;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_axis.TREADY = tready;
  assign wr_en         = beat;
  assign din           = s_axis.TDATA;
  assign frame_cnt     = frame_cnt_q;
  assign err_short     = err_short_q;
  assign err_long      = err_long_q;
  assign busy          = (state_q == RECV);

endmodule

// File: tb/tb_axis_fifo_s_v1_0_s_axis.sv
// Directed bench for the FIFO-fed AXIS slave with an 8-beat frame: a cycle-by-cycle
// vector table plus a hand-written asynchronous-reset sequence.
module tb_axis_fifo_s_v1_0_s_axis;

  localparam int DW  = 32;
  localparam int LEN = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] din;
  logic          wr_en;
  logic          prog_full;
  logic          full;
  logic [15:0]   frame_cnt;
  logic          err_short;
  logic          err_long;
  logic          busy;

  axis_fifo_s_v1_0_s_axis_if #(.C_S_AXIS_TDATA_WIDTH(DW)) s_axis ();

  axis_fifo_s_v1_0_s_axis #(
    .C_S_AXIS_TDATA_WIDTH(DW),
    .LENGTH_OF_FRAME     (LEN)
  ) dut (
    .S_AXIS_ACLK  (clk),
    .S_AXIS_ARESET(rst),
    .s_axis       (s_axis.slave),
    .din          (din),
    .wr_en        (wr_en),
    .prog_full    (prog_full),
    .full         (full),
    .frame_cnt    (frame_cnt),
    .err_short    (err_short),
    .err_long     (err_long),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tv;
    logic        tl;
    logic [31:0] td;
    logic        fl;
    logic        pf;
    logic        tr;
    logic        wr;
    logic        bz;
    logic        es;
    logic        el;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp;
  int   n_bad;

  task automatic add(input logic tv, input logic tl, input int td, input logic fl,
                     input logic pf, input logic tr, input logic wr, input logic bz,
                     input logic es, input logic el, input int fc);
    vec_t v;
    v.tv = tv; v.tl = tl; v.td = 32'(td); v.fl = fl; v.pf = pf;
    v.tr = tr; v.wr = wr; v.bz = bz; v.es = es; v.el = el; v.fc = 16'(fc);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic tv, input logic tl, input int td);
    s_axis.TVALID = tv;
    s_axis.TLAST  = tl;
    s_axis.TDATA  = 32'(td);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst       = 1'b1;
    prog_full = 1'b0;
    full      = 1'b0;
    s_axis.TKEEP = '1;
    drive(1'b1, 1'b0, 0);

    // Frame 1: normal 8-beat frame straight after reset release.
    add(1,0,0,0,0, 0,0,0,0,0,0);                       // IDLE
    add(1,0,0,0,0, 0,0,0,0,0,0);                       // WAIT_SPACE
    for (int i = 0; i < 8; i++) add(1, i == 7, i, 0,0, 1,1,1,0,0,0);
    // prog_full high for 5 cycles at the boundary holds off the next frame.
    for (int i = 0; i < 5; i++) add(1,0,20,0,1, 0,0,0,0,0,1);
    add(1,0,20,0,0, 0,0,0,0,0,1);
    // Frame 2: full for 4 cycles on beat 3; prog_full blip in RECV is ignored.
    for (int i = 0; i < 3; i++) add(1,0,20+i,0,(i == 1), 1,1,1,0,0,1);
    for (int i = 0; i < 4; i++) add(1,0,23,1,0, 0,0,1,0,0,1);
    for (int i = 3; i < 8; i++) add(1, i == 7, 20+i, 0,0, 1,1,1,0,0,1);
    add(0,0,0,0,0, 0,0,0,0,0,2);
    // Frame 3: TLAST on beat 4 -> short; frame 4 then restarts at beat 0.
    for (int i = 0; i < 5; i++) add(1, i == 4, 40+i, 0,0, 1,1,1,0,0,2);
    add(1,0,50,0,0, 0,0,0,1,0,3);
    for (int i = 0; i < 8; i++) add(1, i == 7, 50+i, 0,0, 1,1,1,0,0,3);
    add(0,0,0,0,0, 0,0,0,0,0,4);
    // Frame 5: no TLAST on beat 7 -> long; beats 8..15 form frame 6.
    for (int i = 0; i < 8; i++) add(1,0,60+i,0,0, 1,1,1,0,0,4);
    add(1,0,68,0,0, 0,0,0,0,1,5);
    for (int i = 8; i < 16; i++) add(1, i == 15, 60+i, 0,0, 1,1,1,0,0,5);
    add(0,0,0,0,0, 0,0,0,0,0,6);
    add(0,0,0,0,0, 1,0,1,0,0,6);

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    #1;
    check("rst_tready", 32'(s_axis.TREADY), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_err_short", 32'(err_short), 0);
    check("rst_err_long", 32'(err_long), 0);

    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < tbl.size(); k++) begin
      if (k > 0) @(negedge clk);
      drive(tbl[k].tv, tbl[k].tl, int'(tbl[k].td));
      full      = tbl[k].fl;
      prog_full = tbl[k].pf;
      #1;
      check($sformatf("v%0d_tready", k), 32'(s_axis.TREADY), 32'(tbl[k].tr));
      check($sformatf("v%0d_wr_en", k), 32'(wr_en), 32'(tbl[k].wr));
      check($sformatf("v%0d_busy", k), 32'(busy), 32'(tbl[k].bz));
      check($sformatf("v%0d_err_short", k), 32'(err_short), 32'(tbl[k].es));
      check($sformatf("v%0d_err_long", k), 32'(err_long), 32'(tbl[k].el));
      check($sformatf("v%0d_frame_cnt", k), 32'(frame_cnt), 32'(tbl[k].fc));
      if (tbl[k].wr) check($sformatf("v%0d_din", k), din, tbl[k].td);
    end

    // Asynchronous reset on beat 5 of a frame, applied between clock edges.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 80+i);
      #1;
      check($sformatf("ar_beat%0d_wr_en", i), 32'(wr_en), 1);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 85);
    #1;
    check("ar_beat5_tready", 32'(s_axis.TREADY), 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_async_tready", 32'(s_axis.TREADY), 0);
    check("ar_async_wr_en", 32'(wr_en), 0);
    check("ar_async_busy", 32'(busy), 0);
    check("ar_async_frame_cnt", 32'(frame_cnt), 0);

    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 90);
    #1;
    check("ar_idle_tready", 32'(s_axis.TREADY), 0);
    @(negedge clk);
    #1;
    check("ar_wait_tready", 32'(s_axis.TREADY), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, (i == 7), 90+i);
      #1;
      check($sformatf("ar_f%0d_wr_en", i), 32'(wr_en), 1);
      check($sformatf("ar_f%0d_din", i), din, 32'(90+i));
      check($sformatf("ar_f%0d_err_short", i), 32'(err_short), 0);
      check($sformatf("ar_f%0d_err_long", i), 32'(err_long), 0);
      check($sformatf("ar_f%0d_frame_cnt", i), 32'(frame_cnt), 0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 0);
    #1;
    check("ar_end_frame_cnt", 32'(frame_cnt), 1);
    check("ar_end_busy", 32'(busy), 0);
    check("ar_end_err_short", 32'(err_short), 0);
    check("ar_end_err_long", 32'(err_long), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
